// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//   EX->MEM pipeline register placed directly after the ALU. It is a single-entry
//   register with a valid/ready handshake. It also resolves branches from the ALU
//   zero flag, issues a one-cycle redirect toward fetch, and counts taken branches
//   in a saturating counter.
//
// Parameters
//   DATA_W  ALU result / store data width
//   PC_W    program counter width
//   REG_AW  destination register index width
//   CNT_W   taken-branch counter width
//
// Ports
//   clk, reset                      rising-edge clock, async active-high reset
//   ex_valid / ex_ready             handshake with the EX stage (ex_ready is comb.)
//   alu_result, alu_zero, alu_cntrl ALU outputs and opcode of the instruction
//   is_branch, pc_plus4, branch_off branch information (offset in words)
//   store_data, dest_reg            store operand and write-back register index
//   reg_write, mem_read, mem_write,
//   mem_to_reg                      control bits travelling with the instruction
//   flush_in                        kill the instruction in this stage
//   mem_ready / mem_valid           handshake with the MEM stage
//   mem_*                           registered copies of the captured fields
//   redirect, redirect_pc           one-cycle taken-branch pulse and its target
//   branch_count                    saturating count of taken branches
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [3:0]        alu_cntrl,
  input  logic              is_branch,
  input  logic [PC_W-1:0]   pc_plus4,
  input  logic [PC_W-1:0]   branch_off,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              flush_in,
  input  logic              mem_ready,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_dest_reg,
  output logic              mem_reg_write,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  branch_count
);

  // Only these ALU opcodes are branch comparisons; a zero flag from any other
  // operation (e.g. a SUB that happens to produce zero) must not redirect.
  function automatic logic is_branch_op(input logic [3:0] op);
    logic hit;
    case (op)
      4'd9, 4'd10, 4'd11, 4'd12: hit = 1'b1;
      default:                   hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // State registers and their next-state values.
  logic              valid_q,        valid_d;
  logic [DATA_W-1:0] alu_result_q,   alu_result_d;
  logic [DATA_W-1:0] store_data_q,   store_data_d;
  logic [REG_AW-1:0] dest_reg_q,     dest_reg_d;
  logic              reg_write_q,    reg_write_d;
  logic              mem_read_q,     mem_read_d;
  logic              mem_write_q,    mem_write_d;
  logic              mem_to_reg_q,   mem_to_reg_d;
  logic              redirect_q,     redirect_d;
  logic [PC_W-1:0]   redirect_pc_q,  redirect_pc_d;
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;

  logic              accept_s;
  logic              taken_s;
  logic [PC_W-1:0]   target_s;

  // Single-entry register: free when empty, or when MEM drains it this cycle.
  assign ex_ready = !valid_q || mem_ready;

  // A flushed instruction is never accepted, so it can neither redirect nor count.
  assign accept_s = ex_valid && ex_ready && !flush_in;
  assign taken_s  = accept_s && is_branch && alu_zero && is_branch_op(alu_cntrl);

  // Word offset scaled to bytes; the add wraps modulo 2^PC_W by construction.
  assign target_s = pc_plus4 + {branch_off[PC_W-3:0], 2'b00};

  // Next-state logic for the pipeline register, redirect and counter.
  always_comb begin
    valid_d        = valid_q;
    alu_result_d   = alu_result_q;
    store_data_d   = store_data_q;
    dest_reg_d     = dest_reg_q;
    reg_write_d    = reg_write_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    redirect_d     = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    branch_count_d = branch_count_q;

    if (flush_in) begin
      // Flush wins over both capture and hold; clearing the control bits
      // guarantees the killed slot cannot write anything downstream.
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (accept_s) begin
      valid_d      = 1'b1;
      alu_result_d = alu_result;
      store_data_d = store_data;
      dest_reg_d   = dest_reg;
      mem_to_reg_d = mem_to_reg;
      // A taken branch still occupies the MEM slot but must not write.
      if (taken_s) begin
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end else begin
        reg_write_d = reg_write;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
      end
    end else if (mem_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (taken_s) begin
      redirect_d     = 1'b1;
      redirect_pc_d  = target_s;
      branch_count_d = sat_inc(branch_count_q);
    end else begin
      redirect_d     = 1'b0;
      redirect_pc_d  = redirect_pc_q;
      branch_count_d = branch_count_q;
    end
  end

  // State update with asynchronous reset to an all-zero, write-free state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q        <= 1'b0;
      alu_result_q   <= {DATA_W{1'b0}};
      store_data_q   <= {DATA_W{1'b0}};
      dest_reg_q     <= {REG_AW{1'b0}};
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= {PC_W{1'b0}};
      branch_count_q <= {CNT_W{1'b0}};
    end else begin
      valid_q        <= valid_d;
      alu_result_q   <= alu_result_d;
      store_data_q   <= store_data_d;
      dest_reg_q     <= dest_reg_d;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
      branch_count_q <= branch_count_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_alu_result = alu_result_q;
  assign mem_store_data = store_data_q;
  assign mem_dest_reg   = dest_reg_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_read_o     = mem_read_q;
  assign mem_write_o    = mem_write_q;
  assign mem_to_reg_o   = mem_to_reg_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign branch_count   = branch_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//   Directed testbench for ex_mem_stage. Two instances share all inputs: one
//   with default parameters and one with a 2-bit branch counter, so that
//   counter saturation can be observed with a handful of branches.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [3:0]  alu_cntrl;
  logic        is_branch;
  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic        flush_in;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_dest_reg;
  logic        mem_reg_write, mem_read_o, mem_write_o, mem_to_reg_o;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;

  logic        s_ex_ready, s_mem_valid;
  logic [31:0] s_mem_alu_result, s_mem_store_data;
  logic [4:0]  s_mem_dest_reg;
  logic        s_mem_reg_write, s_mem_read_o, s_mem_write_o, s_mem_to_reg_o;
  logic        s_redirect;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_branch_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cntrl(alu_cntrl),
    .is_branch(is_branch), .pc_plus4(pc_plus4), .branch_off(branch_off),
    .store_data(store_data), .dest_reg(dest_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .flush_in(flush_in), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_dest_reg(mem_dest_reg), .mem_reg_write(mem_reg_write),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .redirect(redirect), .redirect_pc(redirect_pc), .branch_count(branch_count)
  );

  ex_mem_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(s_ex_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cntrl(alu_cntrl),
    .is_branch(is_branch), .pc_plus4(pc_plus4), .branch_off(branch_off),
    .store_data(store_data), .dest_reg(dest_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .flush_in(flush_in), .mem_ready(mem_ready), .mem_valid(s_mem_valid),
    .mem_alu_result(s_mem_alu_result), .mem_store_data(s_mem_store_data),
    .mem_dest_reg(s_mem_dest_reg), .mem_reg_write(s_mem_reg_write),
    .mem_read_o(s_mem_read_o), .mem_write_o(s_mem_write_o), .mem_to_reg_o(s_mem_to_reg_o),
    .redirect(s_redirect), .redirect_pc(s_redirect_pc), .branch_count(s_branch_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; alu_result = 32'd0; alu_zero = 1'b0; alu_cntrl = 4'd0;
    is_branch = 1'b0; pc_plus4 = 32'd0; branch_off = 32'd0; store_data = 32'd0;
    dest_reg = 5'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_to_reg = 1'b0; flush_in = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    // Reset state
    chk("rst_valid",   {63'd0, mem_valid},     64'd0);
    chk("rst_redir",   {63'd0, redirect},      64'd0);
    chk("rst_rpc",     {32'd0, redirect_pc},   64'd0);
    chk("rst_cnt",     {48'd0, branch_count},  64'd0);
    chk("rst_cnt_s",   {62'd0, s_branch_count}, 64'd0);
    reset = 1'b0;
    tick();

    // ADD 5+7 = 12
    ex_valid = 1'b1; alu_cntrl = 4'd2; alu_result = 32'd12; reg_write = 1'b1;
    dest_reg = 5'd3; store_data = 32'hAA; mem_ready = 1'b1;
    tick();
    chk("add_valid", {63'd0, mem_valid},      64'd1);
    chk("add_res",   {32'd0, mem_alu_result}, 64'd12);
    chk("add_rw",    {63'd0, mem_reg_write},  64'd1);
    chk("add_dest",  {59'd0, mem_dest_reg},   64'd3);
    chk("add_sd",    {32'd0, mem_store_data}, 64'hAA);
    chk("add_redir", {63'd0, redirect},       64'd0);

    // Backpressure: next instruction waits while MEM stalls
    alu_result = 32'h55; dest_reg = 5'd7; mem_ready = 1'b0;
    #1;
    chk("bp_ready0", {63'd0, ex_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_res",   {32'd0, mem_alu_result}, 64'd12);
      chk("bp_hold_valid", {63'd0, mem_valid},      64'd1);
    end
    mem_ready = 1'b1;
    #1;
    chk("bp_ready1", {63'd0, ex_ready}, 64'd1);
    tick();
    chk("bp_new_res",  {32'd0, mem_alu_result}, 64'h55);
    chk("bp_new_dest", {59'd0, mem_dest_reg},   64'd7);
    ex_valid = 1'b0;
    tick();
    chk("bp_drain", {63'd0, mem_valid}, 64'd0);

    // Reset in the middle of a transfer
    ex_valid = 1'b1; alu_result = 32'h77;
    tick();
    chk("mid_pre", {63'd0, mem_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_valid", {63'd0, mem_valid},      64'd0);
    chk("mid_res",   {32'd0, mem_alu_result}, 64'd0);
    chk("mid_rw",    {63'd0, mem_reg_write},  64'd0);
    tick();
    tick();
    chk("mid_hold_valid", {63'd0, mem_valid},      64'd0);
    chk("mid_hold_res",   {32'd0, mem_alu_result}, 64'd0);
    reset = 1'b0;
    idle_inputs();
    tick();

    // BEQ taken: 0x100 + (-4 << 2) = 0xF0
    ex_valid = 1'b1; is_branch = 1'b1; alu_cntrl = 4'd9; alu_zero = 1'b1;
    pc_plus4 = 32'h100; branch_off = 32'hFFFF_FFFC; reg_write = 1'b1; mem_write = 1'b1;
    tick();
    chk("beq_redir", {63'd0, redirect},      64'd1);
    chk("beq_rpc",   {32'd0, redirect_pc},   64'hF0);
    chk("beq_cnt",   {48'd0, branch_count},  64'd1);
    chk("beq_rw",    {63'd0, mem_reg_write}, 64'd0);
    chk("beq_mw",    {63'd0, mem_write_o},   64'd0);
    chk("beq_valid", {63'd0, mem_valid},     64'd1);
    // Zero flag from a non-branch opcode is ignored
    alu_cntrl = 4'd3; mem_write = 1'b0;
    tick();
    chk("op3_redir", {63'd0, redirect},      64'd0);
    chk("op3_rpc",   {32'd0, redirect_pc},   64'hF0);
    chk("op3_cnt",   {48'd0, branch_count},  64'd1);
    chk("op3_rw",    {63'd0, mem_reg_write}, 64'd1);
    alu_cntrl = 4'd13;
    tick();
    chk("op13_redir", {63'd0, redirect}, 64'd0);

    // Target wraps: 0xFFFFFFFC + 8 = 0x4
    alu_cntrl = 4'd10; pc_plus4 = 32'hFFFF_FFFC; branch_off = 32'd2;
    tick();
    chk("wrap_rpc",   {32'd0, redirect_pc},    64'h4);
    chk("wrap_cnt",   {48'd0, branch_count},   64'd2);
    chk("wrap_cnt_s", {62'd0, s_branch_count}, 64'd2);

    // Back-to-back taken branches: redirect stays high, small counter saturates
    pc_plus4 = 32'h200; branch_off = 32'd1;
    for (int i = 0; i < 4; i++) begin
      alu_cntrl = (i == 0) ? 4'd11 : ((i == 1) ? 4'd12 : 4'd9);
      tick();
      chk("b2b_redir", {63'd0, redirect},    64'd1);
      chk("b2b_rpc",   {32'd0, redirect_pc}, 64'h204);
    end
    chk("sat_cnt",   {48'd0, branch_count},   64'd6);
    chk("sat_cnt_s", {62'd0, s_branch_count}, 64'd3);

    // Flush beats a simultaneous taken branch
    flush_in = 1'b1; alu_cntrl = 4'd9; pc_plus4 = 32'h300; branch_off = 32'd4;
    tick();
    chk("fl_valid", {63'd0, mem_valid},     64'd0);
    chk("fl_redir", {63'd0, redirect},      64'd0);
    chk("fl_cnt",   {48'd0, branch_count},  64'd6);
    chk("fl_rpc",   {32'd0, redirect_pc},   64'h204);
    chk("fl_rw",    {63'd0, mem_reg_write}, 64'd0);

    // Flush kills a stalled instruction and clears its control bits
    idle_inputs();
    ex_valid = 1'b1; reg_write = 1'b1; mem_read = 1'b1; alu_result = 32'h99; mem_ready = 1'b0;
    tick();
    chk("st_valid", {63'd0, mem_valid},     64'd1);
    chk("st_rw",    {63'd0, mem_reg_write}, 64'd1);
    ex_valid = 1'b0; flush_in = 1'b1;
    tick();
    chk("kill_valid", {63'd0, mem_valid},     64'd0);
    chk("kill_rw",    {63'd0, mem_reg_write}, 64'd0);
    chk("kill_mr",    {63'd0, mem_read_o},    64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
